// File: rtl/arith_ctrl_pkg.sv
// Shared types and constants for the bit-serial arithmetic controller.
package arith_ctrl_pkg;

    // Controller states: wait for a request, step one bit per cycle, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Op select values; sel[1] and sel[0] drive S1 and S0 of the slice.
    localparam logic [1:0] OP_TFR = 2'b00;  // A + cin
    localparam logic [1:0] OP_ADD = 2'b01;  // A + B + cin
    localparam logic [1:0] OP_SUB = 2'b10;  // A + ~B + cin
    localparam logic [1:0] OP_DEC = 2'b11;  // A + all-ones + cin

endpackage

// File: rtl/arith_serial_ctrl_slice.sv
// One-bit arithmetic slice: full adder whose B leg is chosen by S1,S0
// (00 -> 0, 01 -> B, 10 -> ~B, 11 -> 1).
module arith_serial_ctrl_slice (
    input  logic ai,
    input  logic bi,
    input  logic ci,
    input  logic s1,
    input  logic s0,
    output logic h,
    output logic co
);

    logic y;

    // B-leg select followed by a plain full adder.
    always_comb begin
        y  = (s0 & bi) | (s1 & ~bi);
        h  = ai ^ y ^ ci;
        co = (ai & y) | (ci & (ai ^ y));
    end

endmodule

// File: rtl/arith_serial_ctrl.sv
// Bit-serial arithmetic controller: captures an operation, runs it LSB first
// through a single arithmetic slice, then holds the result until taken.
module arith_serial_ctrl
    import arith_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic             cin_q, cin_d;
    logic             co_q, co_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic             slice_ci, slice_h, slice_co;

    // Present the current bit of each captured operand to the slice; the carry
    // chain starts from cin and continues from the previous cycle's carry-out.
    always_comb begin
        a_sh     = a_q >> cnt_q;
        b_sh     = b_q >> cnt_q;
        slice_ci = (cnt_q == '0) ? cin_q : co_q;
    end

    arith_serial_ctrl_slice u_slice (
        .ai (a_sh[0]),
        .bi (b_sh[0]),
        .ci (slice_ci),
        .s1 (sel_q[1]),
        .s0 (sel_q[0]),
        .h  (slice_h),
        .co (slice_co)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cin_d    = cin_q;
        co_d     = co_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    sel_d    = sel;
                    cin_d    = cin;
                    cnt_d    = '0;
                    // Result is built by OR-ing in one bit per cycle, so start clean.
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d = result_q | (WIDTH'(slice_h) << cnt_q);
                co_d     = slice_co;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = slice_co;
                    zero_d  = (result_d == '0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            cin_q    <= 1'b0;
            co_q     <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            cin_q    <= cin_d;
            co_q     <= co_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    // Handshake flags come straight from the state; results come from registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = result_q;
        cout      = cout_q;
        zero      = zero_q;
    end

endmodule

// File: tb/tb_arith_serial_ctrl.sv
// Directed bench for arith_serial_ctrl with hand-computed expected values.
module tb_arith_serial_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    arith_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, count edges to out_valid, check outputs, then handshake.
    // stall: cycles to keep out_ready low in DONE while in_valid stays high.
    // early_ready: hold out_ready high from the start to show it is ignored before DONE.
    task automatic run_op(input string tag,
                          input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] tsel,
                          input logic tcin, input logic [7:0] exp_res, input logic exp_co,
                          input logic exp_z, input int stall, input logic early_ready);
        int edges;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; sel = tsel; cin = tcin; in_valid = 1'b1;
        out_ready = early_ready;
        @(posedge clk);             // accepting edge
        @(negedge clk);
        // Scramble inputs after capture; they must not affect the op.
        a = ~ta; b = ~tb_; sel = ~tsel; cin = ~tcin;
        in_valid = (stall > 0);
        edges = 1;                  // one RUN edge has already passed? no: count from here
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (out_valid) break;
        end
        check({tag, " latency"}, 32'(edges), 32'd8);
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " cout"}, 32'(cout), 32'(exp_co));
        check({tag, " zero"}, 32'(zero), 32'(exp_z));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " stall result"}, 32'(result), 32'(exp_res));
            check({tag, " stall cout"}, 32'(cout), 32'(exp_co));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);             // handshake edge
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
        $display("op %s: a=%02h b=%02h sel=%0d cin=%0d -> result=%02h cout=%0d zero=%0d",
                 tag, ta, tb_, tsel, tcin, result, cout, zero);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = '0; cin = 1'b0;
        #23;
        check("reset result", 32'(result), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        run_op("add", 8'h5A, 8'h33, 2'b01, 1'b0, 8'h8D, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub", 8'h10, 8'h01, 2'b10, 1'b1, 8'h0F, 1'b1, 1'b0, 0, 1'b0);
        run_op("dec", 8'h00, 8'h5C, 2'b11, 1'b0, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
        run_op("tfr", 8'hFF, 8'hA5, 2'b00, 1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        run_op("add_wrap", 8'hFF, 8'h01, 2'b01, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1);
        run_op("stall", 8'h80, 8'h80, 2'b01, 1'b1, 8'h01, 1'b1, 1'b0, 5, 1'b0);

        // Abort mid-RUN after three bits have been processed.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; sel = 2'b01; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort result", 32'(result), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort no out_valid", 32'(out_valid), 32'd0);
        end
        $display("op abort: reset at cnt=3, no output");

        run_op("after_abort", 8'h5A, 8'h33, 2'b01, 1'b0, 8'h8D, 1'b0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
